fu_lsu_multi: RTL

Parametrised successor to the load/store functional unit. Executes LDUR/STUR and LDP/STP over a generic request/grant memory port and splits paired accesses into sequential beats. It has an explicit FSM, a beat counter and in-order read-data capture. It sits beside the ALU and branch FUs behind the reservation station and returns results on the standard FU writeback fields.

---
 rtl/fu_lsu_multi_pkg.sv | 36 +++
 rtl/fu_lsu_multi_if.sv | 22 ++
 rtl/fu_lsu_multi_decode.sv | 68 ++++++
 rtl/fu_lsu_multi.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fu_lsu_multi_pkg.sv
// Shared types and opcode constants for the multi-beat load/store unit.
// Optional pre/post-index forms are enabled by FU_LSU_WRITEBACK_EN.
package lsu_pkg;

  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  // Pair family: inst[31:25]; inst[22] selects load, inst[24:23] the index form
  localparam logic [6:0]  OPC_PAIR = 7'b1010100;

  localparam logic [1:0] SGL_OFFSET = 2'b00;
  localparam logic [1:0] SGL_POST   = 2'b01;
  localparam logic [1:0] SGL_PRE    = 2'b11;
  localparam logic [1:0] PAIR_OFFSET = 2'b10;
  localparam logic [1:0] PAIR_POST   = 2'b01;
  localparam logic [1:0] PAIR_PRE    = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RWAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OFFSET,
    PRE,
    POST
  } addr_mode_t;

  // Sign-extended byte offset: imm9 for single accesses, imm7*8 for pairs.
  function automatic logic [63:0] lsu_offset(input logic [31:0] inst, input logic pair);
    if (pair) return {{54{inst[21]}}, inst[21:15], 3'b000};
    else      return {{55{inst[20]}}, inst[20:12]};
  endfunction

endpackage

// File: rtl/fu_lsu_multi_if.sv
// Request/grant memory port between the load/store unit and memory.
interface fu_lsu_multi_if #(
  parameter int unsigned XLEN = 64
) ();
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/fu_lsu_multi_decode.sv
// Combinational A64 decoder for LDUR/STUR and LDP/STP.
// Pre/post-index forms are recognised only with FU_LSU_WRITEBACK_EN.
module lsu_decode
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     inst,
  output logic            is_load,
  output logic [1:0]      num_beats,
  output logic [XLEN-1:0] offset,
  output addr_mode_t      mode,
  output logic            supported
);

  logic        single;
  logic        pair;
  logic [63:0] off_full;
  logic        unused_bits;

  assign single      = (inst[31:21] == OPC_LDUR) || (inst[31:21] == OPC_STUR);
  assign pair        = (inst[31:25] == OPC_PAIR);
  assign off_full    = lsu_offset(inst, pair);
  assign offset      = off_full[XLEN-1:0];
  assign unused_bits = ^inst[9:0];

  always_comb begin
    is_load   = 1'b0;
    num_beats = 2'd1;
    mode      = OFFSET;
    supported = 1'b0;
    if (single) begin
      is_load = inst[22];
      case (inst[11:10])
        SGL_OFFSET: supported = 1'b1;
`ifdef FU_LSU_WRITEBACK_EN
        SGL_PRE: begin
          supported = 1'b1;
          mode      = PRE;
        end
        SGL_POST: begin
          supported = 1'b1;
          mode      = POST;
        end
`endif
        default: supported = 1'b0;
      endcase
    end else if (pair) begin
      is_load   = inst[22];
      num_beats = 2'd2;
      case (inst[24:23])
        PAIR_OFFSET: supported = 1'b1;
`ifdef FU_LSU_WRITEBACK_EN
        PAIR_PRE: begin
          supported = 1'b1;
          mode      = PRE;
        end
        PAIR_POST: begin
          supported = 1'b1;
          mode      = POST;
        end
`endif
        default: supported = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/fu_lsu_multi.sv
// Load/store functional unit: single and paired accesses split into beats.
// FU_LSU_WRITEBACK_EN adds pre/post-index forms with base writeback on slot 2.
module fu_lsu_multi
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned INST_ID_W  = 8,
  parameter int unsigned PRN_W      = 7,
  parameter int unsigned NUM_OUT    = 3,
  parameter int unsigned BEAT_BYTES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_valid,
  input  logic [31:0]              inst,
  input  logic [INST_ID_W-1:0]     inst_id,
  input  logic [3*XLEN-1:0]        op,
  input  logic [NUM_OUT*PRN_W-1:0] out_prn,
  input  logic [NUM_OUT-1:0]       out_prn_valid,
  output logic                     fu_ready,
  output logic                     fu_out_valid,
  output logic [INST_ID_W-1:0]     fu_out_inst_id,
  output logic [NUM_OUT*PRN_W-1:0] fu_out_prn,
  output logic [NUM_OUT-1:0]       fu_out_prn_valid,
  output logic [NUM_OUT*XLEN-1:0]  fu_out_data,
  output logic [NUM_OUT-1:0]       fu_out_data_valid,
  fu_lsu_multi_if.master           mem
);

  state_t                   state;
  logic                     beat;
  logic                     load_q;
  logic [1:0]               num_beats_q;
  logic [XLEN-1:0]          offset_q;
  addr_mode_t               mode_q;
  logic [INST_ID_W-1:0]     id_q;
  logic [3*XLEN-1:0]        op_q;
  logic [NUM_OUT*PRN_W-1:0] prn_q;
  logic [NUM_OUT-1:0]       prn_valid_q;
  logic [XLEN-1:0]          rdata_q [2];
`ifdef FU_LSU_WRITEBACK_EN
  logic                     wb_q;
`endif

  logic            d_is_load;
  logic [1:0]      d_num_beats;
  logic [XLEN-1:0] d_offset;
  addr_mode_t      d_mode;
  logic            d_supported;

  logic            accept;
  logic            last_beat;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] ea;

  lsu_decode #(.XLEN(XLEN)) u_decode (
    .inst      (inst),
    .is_load   (d_is_load),
    .num_beats (d_num_beats),
    .offset    (d_offset),
    .mode      (d_mode),
    .supported (d_supported)
  );

  assign fu_ready  = (state == IDLE) || (state == DONE);
  assign accept    = inst_valid && fu_ready;
  assign last_beat = beat || (num_beats_q == 2'd1);
  assign base      = op_q[XLEN-1:0];
  assign ea        = base + offset_q;

  assign mem.mem_req   = (state == REQ);
  assign mem.mem_we    = (state == REQ) && !load_q;
  assign mem.mem_addr  = ((mode_q == POST) ? base : ea) + (beat ? XLEN'(BEAT_BYTES) : '0);
  assign mem.mem_wdata = beat ? op_q[3*XLEN-1:2*XLEN] : op_q[2*XLEN-1:XLEN];

  // Decoded fields are latched instead of the raw encoding; the decoder
  // looks at the incoming instruction so the first beat starts right away.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat        <= 1'b0;
      load_q      <= 1'b0;
      num_beats_q <= 2'd1;
      offset_q    <= '0;
      mode_q      <= OFFSET;
      id_q        <= '0;
      op_q        <= '0;
      prn_q       <= '0;
      prn_valid_q <= '0;
      rdata_q[0]  <= '0;
      rdata_q[1]  <= '0;
`ifdef FU_LSU_WRITEBACK_EN
      wb_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            beat        <= 1'b0;
            load_q      <= d_supported && d_is_load;
            num_beats_q <= d_num_beats;
            offset_q    <= d_offset;
            mode_q      <= d_mode;
            id_q        <= inst_id;
            op_q        <= op;
            prn_q       <= out_prn;
            prn_valid_q <= out_prn_valid;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
`ifdef FU_LSU_WRITEBACK_EN
            wb_q        <= d_supported && (d_mode != OFFSET);
`endif
            state       <= d_supported ? REQ : DONE;
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (mem.mem_gnt) begin
            if (load_q) begin
              state <= RWAIT;
            end else if (last_beat) begin
              state <= DONE;
            end else begin
              beat  <= 1'b1;
              state <= REQ;
            end
          end
        end
        RWAIT: begin
          if (mem.mem_rvalid) begin
            rdata_q[beat] <= mem.mem_rdata;
            if (last_beat) begin
              state <= DONE;
            end else begin
              beat  <= 1'b1;
              state <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fu_out_valid     = (state == DONE);
  assign fu_out_inst_id   = id_q;
  assign fu_out_prn       = prn_q;
  assign fu_out_prn_valid = (state == DONE) ? prn_valid_q : '0;

  // Slot layout assumes NUM_OUT >= 3: 0/1 load beats, 2 base writeback.
  always_comb begin
    fu_out_data       = '0;
    fu_out_data_valid = '0;
    fu_out_data[0*XLEN +: XLEN] = rdata_q[0];
    fu_out_data[1*XLEN +: XLEN] = rdata_q[1];
`ifdef FU_LSU_WRITEBACK_EN
    fu_out_data[2*XLEN +: XLEN] = ea;
`endif
    if (state == DONE) begin
      fu_out_data_valid[0] = load_q && prn_valid_q[0];
      fu_out_data_valid[1] = load_q && (num_beats_q == 2'd2) && prn_valid_q[1];
`ifdef FU_LSU_WRITEBACK_EN
      fu_out_data_valid[2] = wb_q && prn_valid_q[2];
`endif
    end
  end

endmodule
